bj_input_arbiter: RTL and testbench

Collects the single-cycle `rise` pulses produced by the per-button synchronizers (deal, hit, stand, new-game) and turns them into an ordered stream of game commands for the blackjack game FSM. Each button gets a per-button lockout against contact chatter and a pending latch. Simultaneous presses are arbitrated round-robin, and granted commands are buffered in a small FIFO. The FIFO is drained through a valid/ready handshake. The block sits between the synchronizer bank and the game controller.

---
 rtl/bj_pkg.sv | 15 +
 rtl/bj_cmd_fifo.sv | 58 +++++
 rtl/bj_input_arbiter.sv | 101 ++++++++++
 tb/tb_bj_input_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bj_pkg.sv
// Shared types for the blackjack button front end: command ids and their width.
// Command id equals the button bit index on the synchronizer bus.
package bj_pkg;

  localparam int BJ_N_BTN = 4;
  localparam int BJ_CMD_W = $clog2(BJ_N_BTN);

  typedef enum logic [BJ_CMD_W-1:0] {
    CMD_DEAL    = BJ_CMD_W'(0),
    CMD_HIT     = BJ_CMD_W'(1),
    CMD_STAND   = BJ_CMD_W'(2),
    CMD_NEWGAME = BJ_CMD_W'(3)
  } bj_cmd_e;

endpackage

// File: rtl/bj_cmd_fifo.sv
// Synchronous command FIFO with a registered head; push to head is one edge.
// A push while full is only taken if a pop happens in the same cycle.
module bj_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      // Head tracks the entry at the next read pointer; a push into an
      // empty (or emptying) queue bypasses the array.
      if (push_ok && (empty || (pop_ok && count == (AW+1)'(1))))
        head <= din;
      else if (pop_ok && count > (AW+1)'(1))
        head <= mem[rd_ptr + AW'(1)];
    end
  end

endmodule

// File: rtl/bj_input_arbiter.sv
// Button rise pulses -> lockout/pending latches -> round-robin grant -> command FIFO.
// Press-to-cmd_valid is 2 edges minimum; cmd_ready low holds the head and stalls grants when full.
module bj_input_arbiter
  import bj_pkg::*;
#(
  parameter int N_BTN   = BJ_N_BTN,
  parameter int HOLDOFF = 8,
  parameter int DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_BTN-1:0]          btn_rise,
  input  logic                      enable,
  output logic                      cmd_valid,
  output logic [$clog2(N_BTN)-1:0]  cmd_id,
  input  logic                      cmd_ready,
  output logic                      overflow,
  output logic                      busy
);

  localparam int IDW = $clog2(N_BTN);
  localparam int LW  = $clog2(HOLDOFF + 1);
  localparam int FCW = $clog2(DEPTH) + 1;

  logic [N_BTN-1:0] pending;
  logic [N_BTN-1:0] accept;
  logic [N_BTN-1:0] grant_oh;
  logic [LW-1:0]    lockout [N_BTN];
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   grant_idx;
  logic             grant_vld;
  logic             can_push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [FCW-1:0]   fifo_count;

  assign cmd_valid = ~fifo_empty;
  assign pop       = cmd_valid & cmd_ready;
  assign can_push  = ~fifo_full | pop;
  assign busy      = (|pending) | (fifo_count != '0);

  always_comb begin
    accept = '0;
    for (int i = 0; i < N_BTN; i++)
      accept[i] = btn_rise[i] & enable & (lockout[i] == '0);
  end

  // Search starts just after the last winner so every button gets a turn.
  always_comb begin
    logic [IDW-1:0] idx;
    idx       = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int off = 1; off <= N_BTN; off++) begin
      idx = IDW'((int'(rr_ptr) + off) % N_BTN);
      if (!grant_vld && can_push && pending[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
    grant_oh = grant_vld ? (N_BTN'(1) << grant_idx) : '0;
  end

  // Lockout reloads to HOLDOFF-1 so that the next accepted rise may come
  // exactly HOLDOFF edges after the previous one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      overflow <= 1'b0;
      rr_ptr   <= IDW'(N_BTN - 1);
      for (int i = 0; i < N_BTN; i++) lockout[i] <= '0;
    end else begin
      pending  <= (pending & ~grant_oh) | accept;
      overflow <= overflow | (|(accept & pending & ~grant_oh));
      if (grant_vld) rr_ptr <= grant_idx;
      for (int i = 0; i < N_BTN; i++) begin
        if (accept[i])
          lockout[i] <= LW'(HOLDOFF - 1);
        else if (lockout[i] != '0)
          lockout[i] <= lockout[i] - LW'(1);
      end
    end
  end

  bj_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (IDW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (grant_vld),
    .din   (grant_idx),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (cmd_id)
  );

endmodule

// File: tb/tb_bj_input_arbiter.sv
// Bench for bj_input_arbiter: vector table, multi-cycle corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_bj_input_arbiter;
  import bj_pkg::*;

  localparam int N   = 4;
  localparam int HO  = 8;
  localparam int DEP = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] btn_rise = '0;
  logic         enable = 1'b1;
  logic         cmd_ready = 1'b0;
  logic         cmd_valid;
  logic [1:0]   cmd_id;
  logic         overflow;
  logic         busy;

  int tests = 0;
  int fails = 0;

  bj_input_arbiter #(.N_BTN(N), .HOLDOFF(HO), .DEPTH(DEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_rise  (btn_rise),
    .enable    (enable),
    .cmd_valid (cmd_valid),
    .cmd_id    (cmd_id),
    .cmd_ready (cmd_ready),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference model: lockout as timestamps of the last accepted press,
  // FIFO as a queue of ids.
  int m_q[$];
  bit m_pend[N];
  int m_last[N];
  int m_ptr;
  bit m_ovf;
  int m_cyc;

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 1'b0;
      m_last[i] = -1000;
    end
    m_ptr = N - 1;
    m_ovf = 1'b0;
    m_cyc = 0;
  endtask

  task automatic model_step(input logic [N-1:0] b, input logic en, input logic rdy);
    bit popq;
    int g;
    g    = -1;
    popq = (m_q.size() > 0) && rdy;
    if (m_q.size() < DEP || popq)
      for (int k = 1; k <= N; k++)
        if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    if (popq) void'(m_q.pop_front());
    if (g >= 0) begin
      m_q.push_back(g);
      m_pend[g] = 1'b0;
      m_ptr = g;
    end
    for (int i = 0; i < N; i++)
      if (b[i] && en && (m_cyc - m_last[i] >= HO)) begin
        m_last[i] = m_cyc;
        if (m_pend[i]) m_ovf = 1'b1;
        else m_pend[i] = 1'b1;
      end
    m_cyc++;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_out(input string nm, input bit v, input int id, input bit ov, input bit bz);
    check({nm, ".cmd_valid"}, int'(cmd_valid), int'(v));
    if (v) check({nm, ".cmd_id"}, int'(cmd_id), id);
    check({nm, ".overflow"}, int'(overflow), int'(ov));
    check({nm, ".busy"}, int'(busy), int'(bz));
  endtask

  task automatic drive(input logic [N-1:0] b, input logic en, input logic rdy);
    btn_rise  = b;
    enable    = en;
    cmd_ready = rdy;
    @(posedge clk);
    #1;
    btn_rise = '0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    btn_rise  = '0;
    enable    = 1'b1;
    cmd_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [N-1:0] btn;
    logic         en;
    logic         rdy;
    logic         v;
    bj_cmd_e      id;
    logic         ov;
    logic         bz;
  } vec_t;

  vec_t tbl[22];
  int   bp_exp[5];

  initial begin
    // Round-robin, drain, lockout boundary and enable gating, one vector per edge.
    tbl[0]  = '{4'b1111, 1'b1, 1'b1, 1'b0, CMD_DEAL,    1'b0, 1'b1};
    tbl[1]  = '{4'b0000, 1'b1, 1'b1, 1'b1, CMD_DEAL,    1'b0, 1'b1};
    tbl[2]  = '{4'b0000, 1'b1, 1'b1, 1'b1, CMD_HIT,     1'b0, 1'b1};
    tbl[3]  = '{4'b0000, 1'b1, 1'b1, 1'b1, CMD_STAND,   1'b0, 1'b1};
    tbl[4]  = '{4'b0000, 1'b1, 1'b1, 1'b1, CMD_NEWGAME, 1'b0, 1'b1};
    tbl[5]  = '{4'b0000, 1'b1, 1'b1, 1'b0, CMD_DEAL,    1'b0, 1'b0};
    tbl[6]  = '{4'b0000, 1'b1, 1'b1, 1'b0, CMD_DEAL,    1'b0, 1'b0};
    tbl[7]  = '{4'b0000, 1'b1, 1'b1, 1'b0, CMD_DEAL,    1'b0, 1'b0};
    tbl[8]  = '{4'b1111, 1'b1, 1'b1, 1'b0, CMD_DEAL,    1'b0, 1'b1};
    tbl[9]  = '{4'b0000, 1'b1, 1'b1, 1'b1, CMD_DEAL,    1'b0, 1'b1};
    tbl[10] = '{4'b0000, 1'b1, 1'b1, 1'b1, CMD_HIT,     1'b0, 1'b1};
    tbl[11] = '{4'b0000, 1'b1, 1'b1, 1'b1, CMD_STAND,   1'b0, 1'b1};
    tbl[12] = '{4'b0000, 1'b1, 1'b1, 1'b1, CMD_NEWGAME, 1'b0, 1'b1};
    tbl[13] = '{4'b0000, 1'b1, 1'b1, 1'b0, CMD_DEAL,    1'b0, 1'b0};
    tbl[14] = '{4'b1111, 1'b1, 1'b1, 1'b0, CMD_DEAL,    1'b0, 1'b0};
    tbl[15] = '{4'b0001, 1'b1, 1'b1, 1'b0, CMD_DEAL,    1'b0, 1'b0};
    tbl[16] = '{4'b0001, 1'b1, 1'b1, 1'b0, CMD_DEAL,    1'b0, 1'b1};
    tbl[17] = '{4'b0000, 1'b1, 1'b1, 1'b1, CMD_DEAL,    1'b0, 1'b1};
    tbl[18] = '{4'b0000, 1'b1, 1'b0, 1'b1, CMD_DEAL,    1'b0, 1'b1};
    tbl[19] = '{4'b0000, 1'b1, 1'b1, 1'b0, CMD_DEAL,    1'b0, 1'b0};
    tbl[20] = '{4'b1000, 1'b0, 1'b1, 1'b0, CMD_DEAL,    1'b0, 1'b0};
    tbl[21] = '{4'b0000, 1'b1, 1'b1, 1'b0, CMD_DEAL,    1'b0, 1'b0};
    bp_exp  = '{0, 1, 2, 3, 0};

    do_reset();
    check_out("reset", 1'b0, 0, 1'b0, 1'b0);
    check("reset.cmd_id", int'(cmd_id), 0);

    for (int t = 0; t < 22; t++) begin
      drive(tbl[t].btn, tbl[t].en, tbl[t].rdy);
      check_out($sformatf("vec%0d", t), tbl[t].v, int'(tbl[t].id), tbl[t].ov, tbl[t].bz);
    end

    // Chatter: pulses 2 edges apart collapse into one command.
    do_reset();
    drive(4'b0100, 1'b1, 1'b0);
    drive(4'b0000, 1'b1, 1'b0);
    drive(4'b0100, 1'b1, 1'b0);
    drive(4'b0000, 1'b1, 1'b0);
    drive(4'b0100, 1'b1, 1'b0);
    repeat (3) drive(4'b0000, 1'b1, 1'b0);
    check_out("chatter.one", 1'b1, 2, 1'b0, 1'b1);
    drive(4'b0100, 1'b1, 1'b0);
    drive(4'b0000, 1'b1, 1'b0);
    drive(4'b0000, 1'b1, 1'b1);
    check_out("chatter.second", 1'b1, 2, 1'b0, 1'b1);
    drive(4'b0000, 1'b1, 1'b1);
    check_out("chatter.empty", 1'b0, 0, 1'b0, 1'b0);

    // Backpressure: fill the FIFO, park one pending, then overflow it.
    do_reset();
    drive(4'b0001, 1'b1, 1'b0);
    drive(4'b0010, 1'b1, 1'b0);
    drive(4'b0100, 1'b1, 1'b0);
    drive(4'b1000, 1'b1, 1'b0);
    repeat (4) drive(4'b0000, 1'b1, 1'b0);
    drive(4'b0001, 1'b1, 1'b0);
    check_out("bp.full", 1'b1, 0, 1'b0, 1'b1);
    repeat (7) drive(4'b0000, 1'b1, 1'b0);
    drive(4'b0001, 1'b1, 1'b0);
    check_out("bp.ovf", 1'b1, 0, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      check_out($sformatf("bp.drain%0d", k), 1'b1, bp_exp[k], 1'b1, 1'b1);
      drive(4'b0000, 1'b1, 1'b1);
    end
    check_out("bp.done", 1'b0, 0, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle with commands queued.
    do_reset();
    drive(4'b0001, 1'b1, 1'b0);
    drive(4'b0010, 1'b1, 1'b0);
    drive(4'b0000, 1'b1, 1'b0);
    check_out("arst.pre", 1'b1, 0, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("arst.now", 1'b0, 0, 1'b0, 1'b0);
    check("arst.cmd_id", int'(cmd_id), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    drive(4'b0001, 1'b1, 1'b0);
    drive(4'b0000, 1'b1, 1'b0);
    check_out("arst.after", 1'b1, 0, 1'b0, 1'b1);

    // Randomized traffic with alternating light/heavy backpressure phases.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] b;
      logic en, rdy;
      bit mbusy;
      b   = N'($urandom & $urandom);
      en  = ($urandom_range(0, 9) != 0);
      rdy = ((c / 300) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      model_step(b, en, rdy);
      drive(b, en, rdy);
      mbusy = (m_q.size() > 0);
      for (int i = 0; i < N; i++) mbusy |= m_pend[i];
      check("rand.cmd_valid", int'(cmd_valid), int'(m_q.size() > 0));
      if (m_q.size() > 0) check("rand.cmd_id", int'(cmd_id), m_q[0]);
      check("rand.overflow", int'(overflow), int'(m_ovf));
      check("rand.busy", int'(busy), int'(mbusy));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
